ebpc_data_packer: RTL and testbench

EBPC_DATA_PACKER -- requirements
Module: ebpc_data_packer

---
 rtl/ebpc_pkg.sv | 13 +
 rtl/ebpc_packer_obuf.sv | 59 +++++
 rtl/ebpc_data_packer.sv | 164 ++++++++++++++++
 tb/tb_ebpc_data_packer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebpc_pkg.sv
// Shared EBPC definitions: block-size limits, packer defaults and packer FSM states.
package ebpc_pkg;

    localparam int unsigned LOG_MAX_WORDS  = 8;
    localparam int unsigned MAX_WORDS      = 2 ** LOG_MAX_WORDS;
    localparam int unsigned PACK_N_DEFAULT = 4;

    typedef enum logic {
        StIdle,
        StFill
    } packer_state_e;

endpackage

// File: rtl/ebpc_packer_obuf.sv
// Output beat register for the data packer: holds data/strb/last stable until accepted.
module ebpc_packer_obuf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PACK_N = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic [DATA_W*PACK_N-1:0] data_i,
    input  logic [PACK_N-1:0]        strb_i,
    input  logic                     last_i,
    output logic [DATA_W*PACK_N-1:0] data_o,
    output logic [PACK_N-1:0]        strb_o,
    output logic                     last_o,
    output logic                     vld_o,
    input  logic                     rdy_i
);

    logic [DATA_W*PACK_N-1:0] data_q, data_d;
    logic [PACK_N-1:0]        strb_q, strb_d;
    logic                     last_q, last_d;
    logic                     vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        strb_d = strb_q;
        last_d = last_q;
        vld_d  = vld_q;
        // A new beat may replace an outgoing one in the same edge, so load wins.
        if (load_i) begin
            data_d = data_i;
            strb_d = strb_i;
            last_d = last_i;
            vld_d  = 1'b1;
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            strb_q <= strb_d;
            last_q <= last_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign strb_o = strb_q;
    assign last_o = last_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/ebpc_data_packer.sv
// Packs decoded words into PACK_N-lane beats per block; optional block counter via
// EBPC_PACKER_BLK_CNT_EN (adds blk_cnt_o).
module ebpc_data_packer
    import ebpc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PACK_N = PACK_N_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [LOG_MAX_WORDS-1:0] num_words_i,
    input  logic                     num_words_vld_i,
    output logic                     num_words_rdy_o,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     vld_i,
    output logic                     rdy_o,
    output logic [DATA_W*PACK_N-1:0] data_o,
    output logic [PACK_N-1:0]        strb_o,
    output logic                     last_o,
    output logic                     vld_o,
    input  logic                     rdy_i
`ifdef EBPC_PACKER_BLK_CNT_EN
    ,
    output logic [15:0]              blk_cnt_o
`endif
);

    localparam int unsigned LANE_W = $clog2(PACK_N);
    localparam int unsigned BEAT_W = DATA_W * PACK_N;

    packer_state_e            state_q, state_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [LOG_MAX_WORDS-1:0] remaining_q, remaining_d;
    logic [BEAT_W-1:0]        acc_data_q, acc_data_d;
    logic [PACK_N-1:0]        acc_strb_q, acc_strb_d;
    logic                     nw_rdy_q, nw_rdy_d;

    logic [BEAT_W-1:0] beat_data;
    logic [PACK_N-1:0] beat_strb;
    logic              complete;
    logic              final_word;
    logic              load;
    logic              rdy;
    logic              obuf_vld;

    assign complete   = (lane_q == LANE_W'(PACK_N - 1)) || (remaining_q == '0);
    assign final_word = (remaining_q == '0);

    always_comb begin
        beat_data = acc_data_q;
        beat_strb = acc_strb_q;
        for (int unsigned i = 0; i < PACK_N; i++) begin
            if (lane_q == LANE_W'(i)) begin
                beat_data[i*DATA_W +: DATA_W] = data_i;
                beat_strb[i]                  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        remaining_d = remaining_q;
        acc_data_d  = acc_data_q;
        acc_strb_d  = acc_strb_q;
        load        = 1'b0;
        rdy         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (num_words_vld_i && nw_rdy_q) begin
                    state_d     = StFill;
                    remaining_d = num_words_i;
                    lane_d      = '0;
                end
            end
            StFill: begin
                // Only a completing word needs the output register free.
                rdy = !(complete && obuf_vld && !rdy_i);
                if (vld_i && rdy) begin
                    if (complete) begin
                        load       = 1'b1;
                        acc_data_d = '0;
                        acc_strb_d = '0;
                        lane_d     = '0;
                    end else begin
                        acc_data_d = beat_data;
                        acc_strb_d = beat_strb;
                        lane_d     = lane_q + LANE_W'(1);
                    end
                    if (final_word) begin
                        state_d = StIdle;
                    end else begin
                        remaining_d = remaining_q - LOG_MAX_WORDS'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so the handshake stays low while reset is asserted.
        nw_rdy_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            lane_q      <= '0;
            remaining_q <= '0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            nw_rdy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            remaining_q <= remaining_d;
            acc_data_q  <= acc_data_d;
            acc_strb_q  <= acc_strb_d;
            nw_rdy_q    <= nw_rdy_d;
        end
    end

    assign num_words_rdy_o = nw_rdy_q;
    assign rdy_o           = rdy;

    ebpc_packer_obuf #(
        .DATA_W (DATA_W),
        .PACK_N (PACK_N)
    ) u_obuf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (load),
        .data_i (beat_data),
        .strb_i (beat_strb),
        .last_i (final_word),
        .data_o (data_o),
        .strb_o (strb_o),
        .last_o (last_o),
        .vld_o  (obuf_vld),
        .rdy_i  (rdy_i)
    );

    assign vld_o = obuf_vld;

`ifdef EBPC_PACKER_BLK_CNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (obuf_vld && rdy_i && last_o) begin
            blk_cnt_d = blk_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`endif

endmodule

// File: tb/tb_ebpc_data_packer.sv
// Scoreboard bench for ebpc_data_packer: directed blocks, stalls, reset and max-size block.
module tb_ebpc_data_packer;
    import ebpc_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_ni = 1'b0;
    logic [LOG_MAX_WORDS-1:0] num_words_i = '0;
    logic                     num_words_vld_i = 1'b0;
    logic                     num_words_rdy_o;
    logic [7:0]               data_i = '0;
    logic                     vld_i = 1'b0;
    logic                     rdy_o;
    logic [31:0]              data_o;
    logic [3:0]               strb_o;
    logic                     last_o;
    logic                     vld_o;
    logic                     rdy_i = 1'b1;
`ifdef EBPC_PACKER_BLK_CNT_EN
    logic [15:0]              blk_cnt_o;
`endif

    ebpc_data_packer #(
        .DATA_W (8),
        .PACK_N (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .num_words_i     (num_words_i),
        .num_words_vld_i (num_words_vld_i),
        .num_words_rdy_o (num_words_rdy_o),
        .data_i          (data_i),
        .vld_i           (vld_i),
        .rdy_o           (rdy_o),
        .data_o          (data_o),
        .strb_o          (strb_o),
        .last_o          (last_o),
        .vld_o           (vld_o),
        .rdy_i           (rdy_i)
`ifdef EBPC_PACKER_BLK_CNT_EN
        ,
        .blk_cnt_o       (blk_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int beats = 0;
    int cycle = 0;
    int stall_cnt = 0;
    bit rand_rdy = 1'b0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l);
        beat_t b;
        b.data = d;
        b.strb = s;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Compare every presented beat against the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rst_ni && vld_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h strb 0x%0h last %0b, expected none",
                         data_o, strb_o, last_o);
            end else begin
                check("beat_data", data_o, exp_q[0].data);
                check("beat_strb", 32'(strb_o), 32'(exp_q[0].strb));
                check("beat_last", 32'(last_o), 32'(exp_q[0].last));
                if (rdy_i) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (stall_cnt > 0) begin
                rdy_i = 1'b0;
                stall_cnt--;
            end else if (rand_rdy) begin
                rdy_i = 1'($urandom_range(0, 1));
            end else begin
                rdy_i = 1'b1;
            end
        end
    end

    task automatic send_nw(input int n);
        bit ok;
        ok = 1'b0;
        num_words_i     = LOG_MAX_WORDS'(n);
        num_words_vld_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (num_words_rdy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        num_words_vld_i = 1'b0;
        check("num_words_handshake", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input logic [7:0] w);
        bit ok;
        ok = 1'b0;
        data_i = w;
        vld_i  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        vld_i = 1'b0;
        check("word_handshake", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_vld_o", 32'(vld_o), 32'd0);
        check("rst_rdy_o", 32'(rdy_o), 32'd0);
        check("rst_nw_rdy", 32'(num_words_rdy_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int b0;
        logic [31:0] d;

        repeat (2) @(posedge clk);
        #1;
        check("reset_vld_o", 32'(vld_o), 32'd0);
        check("reset_data_o", data_o, 32'd0);
        check("reset_strb_o", 32'(strb_o), 32'd0);
        check("reset_last_o", 32'(last_o), 32'd0);
        check("reset_rdy_o", 32'(rdy_o), 32'd0);
        check("reset_nw_rdy", 32'(num_words_rdy_o), 32'd0);
`ifdef EBPC_PACKER_BLK_CNT_EN
        check("reset_blk_cnt", 32'(blk_cnt_o), 32'd0);
`endif
        rst_ni = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_nw_rdy", 32'(num_words_rdy_o), 32'd1);
        check("idle_rdy_o", 32'(rdy_o), 32'd0);
        @(posedge clk);
        #1;

        // 8 words, two full beats, back-to-back
        push(32'h04030201, 4'hF, 1'b0);
        push(32'h08070605, 4'hF, 1'b1);
        send_nw(7);
        t0 = cycle;
        for (int i = 0; i < 8; i++) send_word(8'(i + 1));
        check("one_word_per_cycle", 32'(cycle - t0), 32'd8);
        @(negedge clk);
        check("final_beat_latency", 32'(vld_o && last_o), 32'd1);
        drain();

        // 6 words, partial last beat
        push(32'hA3A2A1A0, 4'hF, 1'b0);
        push(32'h0000A5A4, 4'h3, 1'b1);
        send_nw(5);
        for (int i = 0; i < 6; i++) send_word(8'hA0 + 8'(i));
        drain();

        // single-word block; next num_words accepted on the following cycle
        push(32'h0000005A, 4'h1, 1'b1);
        send_nw(0);
        send_word(8'h5A);
        @(negedge clk);
        check("nw_rdy_after_single", 32'(num_words_rdy_o), 32'd1);
        drain();

        // 16 words with a 5-cycle stall after the first beat
        b0 = beats;
        push(32'h23222120, 4'hF, 1'b0);
        push(32'h27262524, 4'hF, 1'b0);
        push(32'h2B2A2928, 4'hF, 1'b0);
        push(32'h2F2E2D2C, 4'hF, 1'b1);
        send_nw(15);
        for (int i = 0; i < 4; i++) send_word(8'h20 + 8'(i));
        stall_cnt = 5;
        for (int i = 4; i < 7; i++) send_word(8'h20 + 8'(i));
        data_i = 8'h27;
        vld_i  = 1'b1;
        @(negedge clk);
        check("stall_rdy_o_low", 32'(rdy_o), 32'd0);
        check("stall_vld_o_high", 32'(vld_o), 32'd1);
        send_word(8'h27);
        for (int i = 8; i < 16; i++) send_word(8'h20 + 8'(i));
        drain();
        check("stall_beat_count", 32'(beats - b0), 32'd4);

        // reset in the middle of an 8-word block, then a fresh block
        send_nw(7);
        for (int i = 0; i < 3; i++) send_word(8'hE0 + 8'(i));
        pulse_reset();
        push(32'h14131211, 4'hF, 1'b1);
        send_nw(3);
        for (int i = 0; i < 4; i++) send_word(8'h11 + 8'(i));
        drain();

        // largest block: MAX_WORDS words
        for (int k = 0; k < int'(MAX_WORDS) / 4; k++) begin
            d = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
            push(d, 4'hF, k == int'(MAX_WORDS) / 4 - 1);
        end
        send_nw(int'(MAX_WORDS) - 1);
        for (int i = 0; i < int'(MAX_WORDS); i++) send_word(8'(i));
        drain();

        // three blocks back-to-back with random output backpressure
        pulse_reset();
        rand_rdy = 1'b1;
        push(32'h00333231, 4'h7, 1'b1);
        push(32'h44434241, 4'hF, 1'b0);
        push(32'h00000045, 4'h1, 1'b1);
        push(32'h54535251, 4'hF, 1'b1);
        send_nw(2);
        for (int i = 0; i < 3; i++) send_word(8'h31 + 8'(i));
        send_nw(4);
        for (int i = 0; i < 5; i++) send_word(8'h41 + 8'(i));
        send_nw(3);
        for (int i = 0; i < 4; i++) send_word(8'h51 + 8'(i));
        drain();
        rand_rdy = 1'b0;
`ifdef EBPC_PACKER_BLK_CNT_EN
        check("blk_cnt", 32'(blk_cnt_o), 32'd3);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
